fft_frame_ctrl: RTL and testbench

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_pkg.sv | 6 +
 rtl/fft_frame_ctrl_sample_tick_gen.sv | 24 ++
 rtl/fft_frame_ctrl.sv | 93 +++++++++
 tb/tb_fft_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM state encoding and datapath defaults for the FFT front end
package fft_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int FRAME_LEN_DEF = 8;
  typedef enum logic [1:0] {IDLE, FILL, START, BUSY} fsm_state_t;
endpackage

// File: rtl/fft_frame_ctrl_sample_tick_gen.sv
// sample_tick_gen: sample-rate tick counter issuing one-cycle ADC conversion requests
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic fill,
  output logic adc_req
);
  localparam int TW = $clog2(SAMPLE_DIV);
  logic [TW-1:0] tick;
  logic wrap;
  assign wrap = tick == TW'(SAMPLE_DIV - 1);
  // free-running divider while active, parked at zero when idle; request only while filling
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tick <= '0;
      adc_req <= 1'b0;
    end else begin
      tick <= (!run || wrap) ? '0 : tick + 1'b1;
      adc_req <= fill & wrap;
    end
endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames ADC samples into the FFT shift register and hands off to the FFT (FFT_OVERRUN_CNT_EN adds overrun_cnt)
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              adc_req,
  input  logic              adc_dv,
  input  logic [DATA_W-1:0] adc_data,
  output logic              shift_en,
  output logic [DATA_W-1:0] shift_data,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              busy,
  output logic [7:0]        frame_cnt,
  output logic              overrun,
`ifdef FFT_OVERRUN_CNT_EN
  output logic [7:0]        overrun_cnt,
`endif
  input  logic              overrun_clr
);
  localparam int CW = $clog2(FRAME_LEN);
  fsm_state_t state;
  logic [CW-1:0] samp_cnt;
  logic last, drop;
  assign last = samp_cnt == CW'(FRAME_LEN - 1);
  assign drop = adc_dv && (state == START || state == BUSY);

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state != IDLE),
    .fill   (state == FILL),
    .adc_req(adc_req)
  );

  // frame FSM: collect FRAME_LEN samples, kick the FFT, wait for it to finish
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      samp_cnt <= '0;
      shift_en <= 1'b0;
      shift_data <= '0;
      fft_start <= 1'b0;
      busy <= 1'b0;
      frame_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      shift_en <= 1'b0;
      fft_start <= 1'b0;
      overrun <= drop | (overrun & ~overrun_clr);
      case (state)
        IDLE: if (enable) state <= FILL;
        FILL:
          if (!enable) begin
            samp_cnt <= '0;
            state <= IDLE;
          end else if (adc_dv) begin
            shift_en <= 1'b1;
            shift_data <= adc_data;
            samp_cnt <= last ? '0 : samp_cnt + 1'b1;
            if (last) begin
              state <= START;
              busy <= 1'b1;
            end
          end
        START: begin
          state <= BUSY;
          fft_start <= 1'b1;
        end
        BUSY:
          if (fft_done) begin
            frame_cnt <= frame_cnt + 8'd1;
            state <= enable ? FILL : IDLE;
            busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end

`ifdef FFT_OVERRUN_CNT_EN
  // saturating count of samples dropped while the FFT owns the shift register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) overrun_cnt <= '0;
    else overrun_cnt <= drop ? (overrun_cnt == 8'hff ? overrun_cnt : overrun_cnt + 8'd1)
                             : (overrun_clr ? '0 : overrun_cnt);
`endif
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: randomized self-checking bench against a cycle-level behavioural model
module tb_fft_frame_ctrl;
  localparam int DW = 16, FL = 8, DIV = 64;
  typedef enum int {M_IDLE, M_FILL, M_START, M_BUSY} ph_t;

  logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0, adc_dv = 1'b0, fft_done = 1'b0, overrun_clr = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic adc_req, shift_en, fft_start, busy, overrun;
  logic [DW-1:0] shift_data;
  logic [7:0] frame_cnt;
`ifdef FFT_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  fft_frame_ctrl #(.DATA_W(DW), .FRAME_LEN(FL), .SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_req(adc_req), .adc_dv(adc_dv),
    .adc_data(adc_data), .shift_en(shift_en), .shift_data(shift_data), .fft_start(fft_start),
    .fft_done(fft_done), .busy(busy), .frame_cnt(frame_cnt), .overrun(overrun),
`ifdef FFT_OVERRUN_CNT_EN
    .overrun_cnt(overrun_cnt),
`endif
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  ph_t m_st;
  int m_tick, m_cnt, m_frame, m_ocnt;
  bit m_ovr, e_req, e_sen, e_fst, e_busy;
  logic [DW-1:0] e_sdata;

  int adc_cd = 0, adc_lat = 30, adc_n = 0, done_cd = 0, done_lat = 100;
  bit adc_fixed = 1, done_auto = 0, inj_dv = 0, inj_done = 0, inj_clr = 0;
  logic [DW-1:0] adc_val = '0, inj_data = '0;
  int cyc_n = 0, sen_cnt = 0, fst_cnt = 0, last_sen_cyc = -10, fst_gap = -1;
  logic [DW-1:0] sen_log[$];

  task automatic model_reset();
    m_st = M_IDLE; m_tick = 0; m_cnt = 0; m_frame = 0; m_ocnt = 0; m_ovr = 0;
    e_req = 0; e_sen = 0; e_fst = 0; e_busy = 0; e_sdata = '0;
  endtask

  task automatic model_step();
    bit drop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    drop = adc_dv && (m_st == M_START || m_st == M_BUSY);
    e_req = (m_st == M_FILL) && (m_tick == DIV - 1);
    m_tick = (m_st == M_IDLE) ? 0 : (m_tick + 1) % DIV;
    e_sen = (m_st == M_FILL) && enable && adc_dv;
    if (e_sen) e_sdata = adc_data;
    e_fst = (m_st == M_START);
    m_ovr = drop ? 1'b1 : (overrun_clr ? 1'b0 : m_ovr);
    m_ocnt = drop ? ((m_ocnt < 255) ? m_ocnt + 1 : 255) : (overrun_clr ? 0 : m_ocnt);
    case (m_st)
      M_IDLE: if (enable) m_st = M_FILL;
      M_FILL:
        if (!enable) begin
          m_cnt = 0;
          m_st = M_IDLE;
        end else if (adc_dv) begin
          m_cnt++;
          if (m_cnt == FL) begin
            m_cnt = 0;
            m_st = M_START;
          end
        end
      M_START: m_st = M_BUSY;
      default:
        if (fft_done) begin
          m_frame = (m_frame + 1) % 256;
          m_st = enable ? M_FILL : M_IDLE;
        end
    endcase
    e_busy = (m_st == M_START || m_st == M_BUSY);
  endtask

  task automatic cyc();
    bit fire;
    fire = 0;
    if (adc_cd > 0) begin
      adc_cd--;
      fire = (adc_cd == 0);
    end
    adc_dv = fire | inj_dv;
    adc_data = fire ? adc_val : inj_data;
    fft_done = inj_done;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) fft_done = 1'b1;
    end
    overrun_clr = inj_clr;
    inj_dv = 0; inj_done = 0; inj_clr = 0;
    @(posedge clk);
    model_step();
    #1;
    cyc_n++;
    check("adc_req", adc_req, e_req);
    check("shift_en", shift_en, e_sen);
    check("shift_data", shift_data, e_sdata);
    check("fft_start", fft_start, e_fst);
    check("busy", busy, e_busy);
    check("frame_cnt", frame_cnt, m_frame);
    check("overrun", overrun, m_ovr);
`ifdef FFT_OVERRUN_CNT_EN
    check("overrun_cnt", overrun_cnt, m_ocnt);
`endif
    if (shift_en) begin
      sen_cnt++;
      sen_log.push_back(shift_data);
      last_sen_cyc = cyc_n;
    end
    if (fft_start) begin
      fst_cnt++;
      fst_gap = cyc_n - last_sen_cyc;
      if (done_auto) done_cd = done_lat;
    end
    if (adc_req) begin
      adc_cd = adc_lat;
      adc_val = adc_fixed ? DW'(16'h1000 + adc_n) : DW'($urandom);
      adc_n++;
    end
  endtask

  task automatic run_until_fst();
    int s;
    s = fst_cnt;
    for (int i = 0; i < (FL + 2) * DIV + 100 && fst_cnt == s; i++) cyc();
    check("fft_start_timeout", fst_cnt != s, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_adc_req"}, adc_req, 0);
    check({tag, "_shift_en"}, shift_en, 0);
    check({tag, "_shift_data"}, shift_data, 0);
    check({tag, "_fft_start"}, fft_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int s, f;
    model_reset();
    #2 rst_n = 1'b0;
    #20 check_outputs_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // known-data frame, FFT done 100 cycles after start
    adc_fixed = 1; adc_n = 0; adc_lat = 30; done_auto = 1; done_lat = 100;
    sen_log.delete();
    enable = 1'b1;
    run_until_fst();
    check("frame1_nsamples", sen_log.size(), FL);
    for (int i = 0; i < FL && i < sen_log.size(); i++) check("frame1_data", sen_log[i], 32'h1000 + i);
    check("frame1_start_gap", fst_gap, 1);
    repeat (100) cyc();
    check("frame1_cnt", frame_cnt, 1);
    check("frame1_busy", busy, 0);
    s = adc_n;
    for (int i = 0; i < DIV + 2 && adc_n == s; i++) cyc();
    check("refill_adc_req", adc_n != s, 1);

    // drops during BUSY and clear-vs-set priority
    adc_fixed = 0; done_auto = 0;
    run_until_fst();
    s = sen_cnt;
    inj_dv = 1; inj_data = 16'hdead; cyc();
    check("drop_overrun", overrun, 1);
    inj_dv = 1; inj_clr = 1; cyc();
    check("set_wins_clr", overrun, 1);
    check("drop_no_shift", sen_cnt, s);
    inj_clr = 1; cyc();
    check("clr_overrun", overrun, 0);
    inj_done = 1; cyc();
    check("frame2_cnt", frame_cnt, 2);

    // abandon a partial frame
    s = sen_cnt;
    for (int i = 0; i < 6 * DIV && sen_cnt < s + 5; i++) cyc();
    check("partial_5", sen_cnt - s, 5);
    enable = 1'b0;
    f = fst_cnt;
    repeat (2 * DIV) cyc();
    check("partial_no_start", fst_cnt, f);
    enable = 1'b1;
    s = sen_cnt;
    run_until_fst();
    check("fresh_frame_len", sen_cnt - s, FL);
    inj_done = 1; cyc();

    // randomized traffic
    done_auto = 1;
    for (int i = 0; i < 4000; i++) begin
      adc_lat = $urandom_range(1, 40);
      done_lat = $urandom_range(3, 80);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      inj_dv = ($urandom_range(0, 39) == 0);
      inj_data = DW'($urandom);
      inj_clr = ($urandom_range(0, 49) == 0);
      inj_done = ($urandom_range(0, 99) == 0);
      cyc();
    end

    // asynchronous reset in BUSY
    enable = 1'b1; done_auto = 0; adc_lat = 30;
    run_until_fst();
    repeat (3) cyc();
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    model_reset();
    adc_cd = 0; done_cd = 0;
    enable = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    f = fst_cnt;
    inj_done = 1; cyc();
    repeat (5) cyc();
    check("post_reset_frame_cnt", frame_cnt, 0);
    check("post_reset_no_start", fst_cnt, f);

`ifdef FFT_OVERRUN_CNT_EN
    enable = 1'b1;
    run_until_fst();
    for (int i = 0; i < 300; i++) begin
      inj_dv = 1; inj_data = DW'($urandom); cyc();
    end
    check("overrun_cnt_sat", overrun_cnt, 255);
    inj_clr = 1; cyc();
    check("overrun_cnt_clr", overrun_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
